// File: rtl/ark_pkg.sv
// Shared constants and helpers for the AddRoundKey streaming stage.
package ark_pkg;

  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned AES128_ROUNDS = 10;
  localparam int unsigned AES192_ROUNDS = 12;
  localparam int unsigned AES256_ROUNDS = 14;

  function automatic int unsigned idx_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ark_key_store.sv
// Round-key register file with per-slot loaded flags and an asynchronous read port.
// Optional key wipe when built with ARK_ZEROIZE_EN.
module ark_key_store
  import ark_pkg::*;
#(
  parameter int unsigned BLOCK_W    = 128,
  parameter int unsigned NUM_ROUNDS = AES128_ROUNDS,
  parameter int unsigned IDX_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
`ifdef ARK_ZEROIZE_EN
  input  logic               zeroize,
`endif
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [BLOCK_W-1:0] wr_data,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [BLOCK_W-1:0] rd_key,
  output logic               rd_loaded
);

  localparam int unsigned NumKeys = NUM_ROUNDS + 1;

  logic [BLOCK_W-1:0] keys_q [NumKeys];
  logic [NumKeys-1:0] loaded_q;

  // Key contents carry no reset; only the loaded flags are meaningful after rst.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NumKeys; i++) begin
`ifdef ARK_ZEROIZE_EN
      if (zeroize) begin
        keys_q[i] <= '0;
      end else
`endif
      if (wr_en && (wr_idx == IDX_W'(i))) begin
        keys_q[i] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      loaded_q <= '0;
`ifdef ARK_ZEROIZE_EN
    end else if (zeroize) begin
      loaded_q <= '0;
`endif
    end else begin
      for (int i = 0; i < NumKeys; i++) begin
        if (wr_en && (wr_idx == IDX_W'(i))) begin
          loaded_q[i] <= 1'b1;
        end
      end
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write is read-before-write.
  always_comb begin
    rd_key    = '0;
    rd_loaded = 1'b0;
    for (int i = 0; i < NumKeys; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_key    = keys_q[i];
        rd_loaded = loaded_q[i];
      end
    end
  end

endmodule

// File: rtl/add_round_key_stream.sv
// Registered AddRoundKey stage: valid/ready stream, XOR with key selected by round tag.
// Optional zeroize input when built with ARK_ZEROIZE_EN.
module add_round_key_stream
  import ark_pkg::*;
#(
  parameter int unsigned BLOCK_W    = 128,
  parameter int unsigned NUM_ROUNDS = AES128_ROUNDS,
  parameter int unsigned IDX_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
`ifdef ARK_ZEROIZE_EN
  input  logic               zeroize,
`endif
  input  logic               key_wr_en,
  input  logic [IDX_W-1:0]   key_wr_idx,
  input  logic [BLOCK_W-1:0] key_wr_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  input  logic [IDX_W-1:0]   in_round,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic [IDX_W-1:0]   out_round,
  output logic               out_err
);

  localparam logic [IDX_W-1:0] MaxIdx = IDX_W'(NUM_ROUNDS);

  logic [BLOCK_W-1:0] rd_key;
  logic               rd_loaded;
  logic               in_xfer;
  logic               word_err;

  logic               out_valid_q, out_valid_d;
  logic [BLOCK_W-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]   out_round_q, out_round_d;
  logic               out_err_q, out_err_d;

  ark_key_store #(
    .BLOCK_W   (BLOCK_W),
    .NUM_ROUNDS(NUM_ROUNDS),
    .IDX_W     (IDX_W)
  ) u_key_store (
    .clk      (clk),
    .rst      (rst),
`ifdef ARK_ZEROIZE_EN
    .zeroize  (zeroize),
`endif
    .wr_en    (key_wr_en),
    .wr_idx   (key_wr_idx),
    .wr_data  (key_wr_data),
    .rd_idx   (in_round),
    .rd_key   (rd_key),
    .rd_loaded(rd_loaded)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign in_xfer  = in_valid && in_ready;
  assign word_err = (in_round > MaxIdx) || !rd_loaded;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_round_d = out_round_q;
    out_err_d   = out_err_q;
    if (in_xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = word_err ? in_data : (in_data ^ rd_key);
      out_round_d = in_round;
      out_err_d   = word_err;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
`ifdef ARK_ZEROIZE_EN
    // Never let key-derived data survive a wipe.
    if (zeroize) begin
      out_data_d = '0;
      out_err_d  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_round_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_round_q <= out_round_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_round = out_round_q;
  assign out_err   = out_err_q;

endmodule
